mole_scheduler: RTL and testbench



---
 rtl/mole_if.sv | 13 +
 rtl/mole_scheduler.sv | 117 +++++++++++
 tb/tb_mole_scheduler.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/mole_if.sv
// Player/display side of the whack-a-mole game controller.
// The master drives start and hit; the slave (mole_scheduler) returns the map, score and status.
interface mole_if;
    logic       start;
    logic [8:0] hit;
    logic [8:0] map;
    logic [3:0] score;
    logic       game_over;
    logic       busy;

    modport master (output start, hit, input map, score, game_over, busy);
    modport slave  (input start, hit, output map, score, game_over, busy);
endinterface

// File: rtl/mole_scheduler.sv
// Whack-a-mole game controller: spawns moles, times their lifetime, scores hits and sequences games.
// Define MOLE_MISS_PENALTY_EN to deduct one point per hit on an empty hole.
module mole_scheduler #(
    parameter int unsigned MOLE_LIFE = 50_000_000,
    parameter int unsigned SPAWN_GAP = 25_000_000,
    parameter int unsigned GAME_LEN  = 15,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input logic   clk,
    input logic   rst,
    mole_if.slave bus
);
    localparam int unsigned   LW        = $clog2(MOLE_LIFE);
    localparam int unsigned   SW        = $clog2(SPAWN_GAP);
    localparam logic [LW-1:0] LIFE_INIT = LW'(MOLE_LIFE - 1);
    localparam logic [SW-1:0] GAP_INIT  = SW'(SPAWN_GAP - 1);
    localparam logic [7:0]    LEN       = 8'(GAME_LEN);

    typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

    state_t        state, state_n;
    logic [7:0]    lfsr;
    logic [SW-1:0] spawn_cnt;
    logic [7:0]    spawned;
    logic [LW-1:0] life [9];
    logic [8:0]    map_q, map_n, valid, expire, spawn_oh;
    logic [3:0]    score_q, score_n, cand, n_valid;
    logic          busy_q, over_q;
`ifdef MOLE_MISS_PENALTY_EN
    logic [8:0]        invalid;
    logic [3:0]        n_invalid;
    logic signed [5:0] sum;
`else
    logic [4:0]        sum;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE, OVER: if (bus.start) state_n = PLAY;
            PLAY:       if (spawned == LEN && map_q == '0) state_n = OVER;
            default:    state_n = IDLE;
        endcase
    end

    // Next map/score in PLAY; a hit takes priority over expiry on the same hole.
    always_comb begin
        valid  = bus.hit & map_q;
        expire = '0;
        for (int unsigned i = 0; i < 9; i++)
            expire[i] = map_q[i] & ~bus.hit[i] & (life[i] == '0);
        cand     = (lfsr[3:0] >= 4'd9) ? lfsr[3:0] - 4'd9 : lfsr[3:0];
        spawn_oh = '0;
        if (spawn_cnt == '0 && spawned < LEN && !map_q[cand])
            spawn_oh[cand] = 1'b1;
        map_n   = (map_q & ~valid & ~expire) | spawn_oh;
        n_valid = 4'($countones(valid));
`ifdef MOLE_MISS_PENALTY_EN
        invalid   = bus.hit & ~map_q;
        n_invalid = 4'($countones(invalid));
        sum       = $signed({2'b00, score_q}) + $signed({2'b00, n_valid})
                  - $signed({2'b00, n_invalid});
        if (sum > 6'sd15)     score_n = 4'd15;
        else if (sum < 6'sd0) score_n = '0;
        else                  score_n = sum[3:0];
`else
        sum     = {1'b0, score_q} + {1'b0, n_valid};
        score_n = (sum > 5'd15) ? 4'd15 : sum[3:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr      <= LFSR_SEED;
            map_q     <= '0;
            score_q   <= '0;
            spawn_cnt <= '0;
            spawned   <= '0;
            busy_q    <= 1'b0;
            over_q    <= 1'b0;
            for (int unsigned i = 0; i < 9; i++) life[i] <= '0;
        end else begin
            lfsr   <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            busy_q <= (state_n == PLAY);
            over_q <= (state_n == OVER);
            if (state != PLAY) begin
                if (state_n == PLAY) begin
                    map_q     <= '0;
                    score_q   <= '0;
                    spawned   <= '0;
                    spawn_cnt <= GAP_INIT;
                end
            end else if (state_n == OVER) begin
                map_q <= '0;
            end else begin
                map_q     <= map_n;
                score_q   <= score_n;
                spawn_cnt <= (spawn_cnt == '0) ? GAP_INIT : spawn_cnt - SW'(1);
                if (spawn_oh != '0) spawned <= spawned + 8'd1;
                for (int unsigned i = 0; i < 9; i++) begin
                    if (spawn_oh[i])                    life[i] <= LIFE_INIT;
                    else if (map_q[i] && life[i] != '0) life[i] <= life[i] - LW'(1);
                end
            end
        end
    end

    assign bus.map       = map_q;
    assign bus.score     = score_q;
    assign bus.busy      = busy_q;
    assign bus.game_over = over_q;
endmodule

// File: tb/tb_mole_scheduler.sv
// Self-checking bench for mole_scheduler: a game-level model checked every cycle on two
// instances (short-life game and a long game that reaches the score ceiling), plus directed literals.
module tb_mole_scheduler;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    mole_if ia ();
    mole_if ib ();

    mole_scheduler #(.MOLE_LIFE(4), .SPAWN_GAP(3), .GAME_LEN(3), .LFSR_SEED(8'hA5))
        u_a (.clk(clk), .rst(rst_a), .bus(ia.slave));
    mole_scheduler #(.MOLE_LIFE(8), .SPAWN_GAP(3), .GAME_LEN(20), .LFSR_SEED(8'hA5))
        u_b (.clk(clk), .rst(rst_b), .bus(ib.slave));

    // mode: 0 idle, 1 play, 2 over; age = cycles the mole has been visible
    typedef struct packed {
        logic [1:0]      mode;
        logic [7:0]      lfsr;
        logic [8:0]      map;
        logic [4:0]      score;
        int              spawned;
        int              t;
        logic [8:0][7:0] age;
    } mdl_t;

    mdl_t ma, mb;
    int   errors = 0;
    int   checks = 0;

`ifdef MOLE_MISS_PENALTY_EN
    localparam int PEN = 1;
`else
    localparam int PEN = 0;
`endif

    function automatic mdl_t step(mdl_t m, logic rst, logic start, logic [8:0] hit,
                                  int life, int gap, int len);
        mdl_t       n;
        int         good, bad, s, h;
        logic [8:0] nm;
        n = m;
        if (rst) begin
            n = '0;
            n.lfsr = 8'hA5;
            return n;
        end
        n.lfsr = {m.lfsr[6:0], m.lfsr[7] ^ m.lfsr[5] ^ m.lfsr[4] ^ m.lfsr[3]};
        if (m.mode != 2'd1) begin
            if (start) begin
                n.mode = 2'd1; n.map = '0; n.score = '0; n.spawned = 0; n.t = 0;
            end
            return n;
        end
        if (m.spawned == len && m.map == '0) begin
            n.mode = 2'd2;
            return n;
        end
        good = 0; bad = 0; nm = m.map;
        for (int i = 0; i < 9; i++) begin
            if (hit[i]) begin
                if (m.map[i]) begin good++; nm[i] = 1'b0; end
                else bad++;
            end else if (m.map[i] && int'(m.age[i]) == life) begin
                nm[i] = 1'b0;
            end
            n.age[i] = m.age[i] + 8'd1;
        end
        n.t = m.t + 1;
        if (n.t % gap == 0 && m.spawned < len) begin
            h = int'(m.lfsr[3:0]);
            if (h >= 9) h -= 9;
            if (!m.map[h]) begin
                nm[h] = 1'b1; n.age[h] = 8'd1; n.spawned = m.spawned + 1;
            end
        end
        s = int'(m.score) + good - PEN * bad;
        if (s > 15) s = 15;
        if (s < 0)  s = 0;
        n.score = 5'(s);
        n.map   = nm;
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always begin
        @(posedge clk);
        ma = step(ma, rst_a, ia.start, ia.hit, 4, 3, 3);
        mb = step(mb, rst_b, ib.start, ib.hit, 8, 3, 20);
        #1;
        chk("a_map",   ia.map,       ma.map);
        chk("a_score", ia.score,     ma.score);
        chk("a_busy",  ia.busy,      ma.mode == 2'd1);
        chk("a_over",  ia.game_over, ma.mode == 2'd2);
        chk("b_map",   ib.map,       mb.map);
        chk("b_score", ib.score,     mb.score);
        chk("b_busy",  ib.busy,      mb.mode == 2'd1);
        chk("b_over",  ib.game_over, mb.mode == 2'd2);
    end

    task automatic a_script();
        int ok;
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0; ia.start = 1'b1;
        @(negedge clk);
        ia.start = 1'b0;
        chk("busy_after_start", ia.busy, 1);
        chk("map_after_start", ia.map, 0);
        repeat (2) @(negedge clk);
        chk("pre_spawn_map", ia.map, 0);
        @(negedge clk);
        chk("first_spawn_hole1", ia.map, 9'h002);
        repeat (3) @(negedge clk);
        chk("second_spawn_hole3", ia.map, 9'h00A);
        ia.hit = 9'h008;
        @(negedge clk);
        chk("hit_and_expire_map", ia.map, 0);
        chk("score_first_hit", ia.score, 1);
        ia.hit = 9'h008;
        @(negedge clk);
        ia.hit = '0;
        chk("down_hole_hit", ia.score, 1 - PEN);
        @(negedge clk);
        chk("third_spawn_hole4", ia.map, 9'h010);
        repeat (4) @(negedge clk);
        chk("last_clear_map", ia.map, 0);
        chk("last_clear_busy", ia.busy, 1);
        @(negedge clk);
        chk("over_flag", ia.game_over, 1);
        chk("over_busy", ia.busy, 0);
        chk("over_score_held", ia.score, 1 - PEN);
        ia.start = 1'b1;
        @(negedge clk);
        ia.start = 1'b0;
        chk("restart_score", ia.score, 0);
        chk("restart_busy", ia.busy, 1);
        chk("restart_over", ia.game_over, 0);
        ia.start = 1'b1;
        @(negedge clk);
        ia.start = 1'b0;
        ok = 0;
        for (int k = 0; k < 60 && ok == 0; k++) begin
            if (ma.score == 5'd2 && ma.map != '0) ok = 1;
            else begin
                ia.hit = (ma.score < 5'd2) ? ma.map : '0;
                @(negedge clk);
            end
        end
        ia.hit = '0;
        chk("reach_score2_with_mole", ok, 1);
        chk("mid_game_score2", ia.score, 2);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        chk("rst_map", ia.map, 0);
        chk("rst_score", ia.score, 0);
        chk("rst_busy", ia.busy, 0);
        chk("rst_over", ia.game_over, 0);
        repeat (5) @(negedge clk);
    endtask

    task automatic b_script();
        int pairs;
        pairs = 0;
        ib.start = 1'b1;
        @(negedge clk);
        ib.start = 1'b0;
        for (int k = 0; k < 400 && mb.mode != 2'd2; k++) begin
            if ($countones(mb.map) >= 2) begin
                ib.hit = mb.map;
                pairs++;
            end else begin
                ib.hit = '0;
            end
            @(negedge clk);
        end
        ib.hit = '0;
        chk("b_game_over", ib.game_over, 1);
        chk("b_score_saturated", ib.score, 15);
        chk("b_double_hits_seen", pairs > 0, 1);
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        ia.start = 1'b0; ia.hit = '0;
        ib.start = 1'b0; ib.hit = '0;
        repeat (3) @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;
        repeat (50) @(negedge clk);
        chk("idle_map", ia.map, 0);
        chk("idle_busy", ia.busy, 0);
        chk("idle_over", ia.game_over, 0);
        fork
            a_script();
            b_script();
        join
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
